// File: rtl/mips32_mem_arbiter_pkg.sv
// Shared types and constants for the pipe_MIPS32 unified-memory arbiter.
// The read-return source tags live here so the tag pipe and the top agree on encoding.
package mips32_mem_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;

  typedef logic [1:0] src_tag_t;

  localparam src_tag_t SRC_NONE = 2'd0;
  localparam src_tag_t SRC_IF   = 2'd1;
  localparam src_tag_t SRC_DM   = 2'd2;
  localparam src_tag_t SRC_DBG  = 2'd3;

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// Requester, memory-side and status signals of the arbiter.
// The slave modport is the arbiter's view; master is the core/memory/bench view.
interface mips32_mem_arbiter_if
  import mips32_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;

  logic          dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;

  logic          if_req, if_gnt, if_rvalid, stall_if;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;

  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [15:0]   conflict_cnt;

  modport slave (
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  if_req, if_addr, mem_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output if_gnt, if_rvalid, if_rdata, stall_if,
    output mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
  );

  modport master (
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output if_req, if_addr, mem_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  if_gnt, if_rvalid, if_rdata, stall_if,
    input  mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
  );

endinterface

// File: rtl/mips32_rd_tag_pipe.sv
// Delays the source tag of each issued access by RD_LAT cycles so it lines up
// with mem_rdata; reset flushes every stage so in-flight reads are dropped.
module mips32_rd_tag_pipe
  import mips32_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  src_tag_t tag_in,
  output src_tag_t tag_out
);

  src_tag_t tag_q [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= SRC_NONE;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out = tag_q[RD_LAT-1];

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter for pipe_MIPS32: debug > MEM stage > IF, with an
// anti-starvation override for IF and tagged in-order read return.
module mips32_mem_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips32_mem_arbiter_if.slave  bus
);

  logic          dbgGnt, dmGnt, ifGnt, forceIf;
  logic          memEn, memWe;
  logic [AW-1:0] memAddr, memAddr_q;
  logic [DW-1:0] memWdata, memWdata_q;
  logic [3:0]    starveCnt_q, starveCnt_d;
  logic [15:0]   conflictCnt_q, conflictCnt_d;
  logic [1:0]    reqCount;
  src_tag_t      issueTag, tagOut;
  logic [DW-1:0] ifRdata_q, dmRdata_q, dbgRdata_q;

  // Grants are gated by rst_n so nothing is issued while reset is held.
  always_comb begin
    forceIf = bus.if_req && (starveCnt_q == 4'(STARVE_LIMIT));
    dbgGnt  = rst_n && bus.dbg_req;
    dmGnt   = rst_n && bus.dm_req && !bus.dbg_req && !forceIf;
    ifGnt   = rst_n && bus.if_req && !bus.dbg_req && (!bus.dm_req || forceIf);
  end

  always_comb begin
    memEn    = dbgGnt || dmGnt || ifGnt;
    memWe    = 1'b0;
    memAddr  = memAddr_q;
    memWdata = memWdata_q;
    issueTag = SRC_NONE;
    if (dbgGnt) begin
      memWe    = bus.dbg_we;
      memAddr  = bus.dbg_addr;
      memWdata = bus.dbg_wdata;
      issueTag = bus.dbg_we ? SRC_NONE : SRC_DBG;
    end else if (dmGnt) begin
      memWe    = bus.dm_we;
      memAddr  = bus.dm_addr;
      memWdata = bus.dm_wdata;
      issueTag = bus.dm_we ? SRC_NONE : SRC_DM;
    end else if (ifGnt) begin
      memAddr  = bus.if_addr;
      issueTag = SRC_IF;
    end
  end

  always_comb begin
    reqCount      = 2'(bus.dbg_req) + 2'(bus.dm_req) + 2'(bus.if_req);
    conflictCnt_d = conflictCnt_q;
    if (reqCount >= 2'd2 && conflictCnt_q != 16'hFFFF) conflictCnt_d = conflictCnt_q + 16'd1;
    starveCnt_d = starveCnt_q;
    if (!bus.if_req || ifGnt)                   starveCnt_d = '0;
    else if (starveCnt_q != 4'(STARVE_LIMIT))   starveCnt_d = starveCnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memAddr_q     <= '0;
      memWdata_q    <= '0;
      starveCnt_q   <= '0;
      conflictCnt_q <= '0;
    end else begin
      memAddr_q     <= memAddr;
      memWdata_q    <= memWdata;
      starveCnt_q   <= starveCnt_d;
      conflictCnt_q <= conflictCnt_d;
    end
  end

  mips32_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (issueTag),
    .tag_out (tagOut)
  );

  // Each requester keeps its last returned word until its next read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifRdata_q  <= '0;
      dmRdata_q  <= '0;
      dbgRdata_q <= '0;
    end else begin
      if (tagOut == SRC_IF)  ifRdata_q  <= bus.mem_rdata;
      if (tagOut == SRC_DM)  dmRdata_q  <= bus.mem_rdata;
      if (tagOut == SRC_DBG) dbgRdata_q <= bus.mem_rdata;
    end
  end

  assign bus.dbg_gnt      = dbgGnt;
  assign bus.dm_gnt       = dmGnt;
  assign bus.if_gnt       = ifGnt;
  assign bus.stall_if     = rst_n && bus.if_req && !ifGnt;
  assign bus.mem_en       = memEn;
  assign bus.mem_we       = memWe;
  assign bus.mem_addr     = memAddr;
  assign bus.mem_wdata    = memWdata;
  assign bus.conflict_cnt = conflictCnt_q;

  assign bus.if_rvalid  = (tagOut == SRC_IF);
  assign bus.dm_rvalid  = (tagOut == SRC_DM);
  assign bus.dbg_rvalid = (tagOut == SRC_DBG);
  assign bus.if_rdata   = (tagOut == SRC_IF)  ? bus.mem_rdata : ifRdata_q;
  assign bus.dm_rdata   = (tagOut == SRC_DM)  ? bus.mem_rdata : dmRdata_q;
  assign bus.dbg_rdata  = (tagOut == SRC_DBG) ? bus.mem_rdata : dbgRdata_q;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Scoreboard bench for mips32_mem_arbiter with a write-first memory model;
// read expectations are queued at grant time and checked on return.
module tb_mips32_mem_arbiter;
  import mips32_mem_pkg::*;

  localparam int AW           = 10;
  localparam int DW           = 32;
  localparam int RD_LAT       = 3;
  localparam int STARVE_LIMIT = 4;

  typedef struct {
    src_tag_t    src;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycleCnt = 0;
  int   compared = 0;
  int   mismatched = 0;

  exp_t        sbQ [$];
  logic [31:0] pendExp [4];
  logic [31:0] prog [9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                            32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
  logic [2:0]  t3Gnt   [10] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001,
                                3'b010, 3'b010, 3'b010, 3'b010, 3'b001};
  logic        t3Stall [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  logic [DW-1:0] memArr [1024];
  logic [DW-1:0] rdPipe [RD_LAT];

  mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mips32_mem_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  // Memory model: write-first single port, read data RD_LAT cycles after issue
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) memArr[bus.mem_addr] <= bus.mem_wdata;
    rdPipe[0] <= (bus.mem_en && !bus.mem_we) ? memArr[bus.mem_addr] : 32'hDEADBEEF;
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign bus.mem_rdata = rdPipe[RD_LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // Issue tracker: every granted read pushes the value its requester expects
  always @(negedge clk) begin
    if (bus.dbg_gnt && !bus.dbg_we) sbQ.push_back('{SRC_DBG, pendExp[SRC_DBG], cycleCnt});
    if (bus.dm_gnt && !bus.dm_we)   sbQ.push_back('{SRC_DM, pendExp[SRC_DM], cycleCnt});
    if (bus.if_gnt)                 sbQ.push_back('{SRC_IF, pendExp[SRC_IF], cycleCnt});
  end

  logic [2:0]  monRv;
  src_tag_t    monSrc;
  logic [31:0] monData;
  exp_t        monExp;

  // Monitor: pops one expectation per returned read, checks source, data and latency
  always @(negedge clk) begin
    monRv = {bus.dbg_rvalid, bus.dm_rvalid, bus.if_rvalid};
    if (monRv != 3'b000) begin
      if ($countones(monRv) > 1) checkOutput("rvalid_onehot", {29'b0, monRv}, 32'd0);
      if (monRv[2])      begin monSrc = SRC_DBG; monData = bus.dbg_rdata; end
      else if (monRv[1]) begin monSrc = SRC_DM;  monData = bus.dm_rdata;  end
      else               begin monSrc = SRC_IF;  monData = bus.if_rdata;  end
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_rvalid", {29'b0, monRv}, 32'd0);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("rd_src", {30'b0, monSrc}, {30'b0, monExp.src});
        checkOutput("rd_data", monData, monExp.data);
        checkOutput("rd_latency", cycleCnt - monExp.cyc, RD_LAT);
      end
    end
  end

  task automatic applyStimulus(input src_tag_t src, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] expRd);
    pendExp[src] = expRd;
    case (src)
      SRC_DBG: begin bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata; end
      SRC_DM:  begin bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata; end
      SRC_IF:  begin bus.if_req = 1'b1; bus.if_addr = addr; end
      default: ;
    endcase
  endtask

  task automatic dropReq(input src_tag_t src);
    case (src)
      SRC_DBG: bus.dbg_req = 1'b0;
      SRC_DM:  bus.dm_req = 1'b0;
      SRC_IF:  bus.if_req = 1'b0;
      default: ;
    endcase
  endtask

  task automatic stepCycle(input string name, input logic [2:0] expGnt, input logic expStall);
    @(negedge clk);
    checkOutput({name, "_gnt"}, {29'b0, bus.dbg_gnt, bus.dm_gnt, bus.if_gnt}, {29'b0, expGnt});
    checkOutput({name, "_stall"}, {31'b0, bus.stall_if}, {31'b0, expStall});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_gnt"}, {29'b0, bus.dbg_gnt, bus.dm_gnt, bus.if_gnt}, 32'd0);
    checkOutput({name, "_rvalid"}, {29'b0, bus.dbg_rvalid, bus.dm_rvalid, bus.if_rvalid}, 32'd0);
    checkOutput({name, "_mem_en_we"}, {30'b0, bus.mem_en, bus.mem_we}, 32'd0);
    checkOutput({name, "_stall_if"}, {31'b0, bus.stall_if}, 32'd0);
    checkOutput({name, "_conflict"}, {16'b0, bus.conflict_cnt}, 32'd0);
  endtask

  initial begin
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    bus.dm_req = 0;  bus.dm_we = 0;  bus.dm_addr = '0;  bus.dm_wdata = '0;
    bus.if_req = 0;  bus.if_addr = '0;
    for (int i = 0; i < 4; i++) pendExp[i] = '0;

    repeat (2) @(negedge clk);
    checkResetState("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] test 1: debug preload and readback");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(SRC_DBG, 1'b1, AW'(i), prog[i], 32'd0);
      stepCycle("t1_wr", 3'b100, 1'b0);
    end
    for (int i = 0; i < 9; i++) begin
      applyStimulus(SRC_DBG, 1'b0, AW'(i), 32'd0, prog[i]);
      stepCycle("t1_rd", 3'b100, 1'b0);
    end
    dropReq(SRC_DBG);
    idle(RD_LAT + 2);

    $display("[TB] test 2: three simultaneous requests");
    applyStimulus(SRC_DBG, 1'b0, 10'd0, 32'd0, prog[0]);
    applyStimulus(SRC_DM,  1'b0, 10'd1, 32'd0, prog[1]);
    applyStimulus(SRC_IF,  1'b0, 10'd2, 32'd0, prog[2]);
    stepCycle("t2_c1", 3'b100, 1'b1);
    dropReq(SRC_DBG);
    stepCycle("t2_c2", 3'b010, 1'b1);
    dropReq(SRC_DM);
    stepCycle("t2_c3", 3'b001, 1'b0);
    dropReq(SRC_IF);
    idle(RD_LAT + 2);

    $display("[TB] test 3: IF starvation override");
    applyStimulus(SRC_DM, 1'b0, 10'd8, 32'd0, prog[8]);
    applyStimulus(SRC_IF, 1'b0, 10'd4, 32'd0, prog[4]);
    for (int i = 0; i < 10; i++) stepCycle("t3", t3Gnt[i], t3Stall[i]);
    dropReq(SRC_DM);
    dropReq(SRC_IF);
    idle(RD_LAT + 2);

    $display("[TB] test 4: back-to-back mixed reads");
    applyStimulus(SRC_IF, 1'b0, 10'd5, 32'd0, 32'h00222000);
    stepCycle("t4_if", 3'b001, 1'b0);
    dropReq(SRC_IF);
    applyStimulus(SRC_DM, 1'b0, 10'd7, 32'd0, 32'h00832800);
    stepCycle("t4_dm", 3'b010, 1'b0);
    dropReq(SRC_DM);
    idle(RD_LAT + 2);

    $display("[TB] test 5: store then fetch same address");
    applyStimulus(SRC_DM, 1'b1, 10'd20, 32'h00001234, 32'd0);
    stepCycle("t5_sw", 3'b010, 1'b0);
    dropReq(SRC_DM);
    applyStimulus(SRC_IF, 1'b0, 10'd20, 32'd0, 32'h00001234);
    stepCycle("t5_if", 3'b001, 1'b0);
    dropReq(SRC_IF);
    idle(RD_LAT + 2);
    @(negedge clk);
    checkOutput("conflict_cnt", {16'b0, bus.conflict_cnt}, 32'd12);
    checkOutput("idle_mem_en_we", {30'b0, bus.mem_en, bus.mem_we}, 32'd0);
    checkOutput("idle_mem_addr_hold", {22'b0, bus.mem_addr}, 32'd20);
    checkOutput("idle_mem_wdata_hold", bus.mem_wdata, 32'h00001234);
    @(posedge clk);
    #1;

    $display("[TB] test 6: reset with a read in flight");
    applyStimulus(SRC_DBG, 1'b0, 10'd1, 32'd0, prog[1]);
    stepCycle("t6_rd", 3'b100, 1'b0);
    dropReq(SRC_DBG);
    rst_n = 1'b0;
    sbQ.delete();
    applyStimulus(SRC_DM, 1'b0, 10'd3, 32'd0, 32'd0);
    applyStimulus(SRC_IF, 1'b0, 10'd4, 32'd0, 32'd0);
    repeat (RD_LAT + 1) begin
      @(negedge clk);
      checkResetState("t6_in_reset");
    end
    dropReq(SRC_DM);
    dropReq(SRC_IF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(RD_LAT + 3);
    @(negedge clk);
    checkOutput("t6_conflict_after", {16'b0, bus.conflict_cnt}, 32'd0);
    checkOutput("sb_empty", sbQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
